// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and length-block helper for the SHA-256 block padder.
package sha256_pkg;

  localparam int SHA256_BLOCK_BYTES      = 64;
  localparam int SHA256_BLOCK_W          = 512;
  localparam int SHA256_LEN_W            = 64;
  localparam logic [7:0] SHA256_PAD_BYTE = 8'h80;
  localparam int SHA256_LEN_OFFSET_BYTES = 56;
  localparam int SHA256_OFF_W            = 7;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_EMIT_LAST,
    ST_EXTRA
  } pad_state_e;

  // Trailing block that only carries the length, optionally led by the pad byte.
  function automatic logic [SHA256_BLOCK_W-1:0] sha256_len_block(
    input logic                    lead_pad,
    input logic [SHA256_LEN_W-1:0] msg_bits
  );
    logic [SHA256_BLOCK_W-1:0] blk;
    blk = '0;
    blk[SHA256_BLOCK_W-1 -: 8]    = lead_pad ? SHA256_PAD_BYTE : 8'h00;
    blk[SHA256_LEN_W-1:0]         = msg_bits;
    return blk;
  endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// Per-byte masks for one input beat landing at a block offset: data keep, 0x80 position, zero tail.
module sha256_pad_mask
  import sha256_pkg::*;
#(
  parameter int IF_BYTES = 32,
  parameter int BYTES_W  = $clog2(IF_BYTES + 1)
) (
  input  logic [SHA256_OFF_W-1:0]       offset,
  input  logic [BYTES_W-1:0]            nbytes,
  output logic [SHA256_BLOCK_BYTES-1:0] keep,
  output logic [SHA256_BLOCK_BYTES-1:0] pad,
  output logic [SHA256_BLOCK_BYTES-1:0] tail
);

  logic [7:0] start;
  logic [7:0] fill;

  assign start = 8'(offset);
  assign fill  = 8'(offset) + 8'(nbytes);

  // Bit gi of each mask refers to block byte gi (byte 0 is the MSB byte).
  generate
    for (genvar gi = 0; gi < SHA256_BLOCK_BYTES; gi++) begin : g_byte
      localparam logic [7:0] IDX = 8'(gi);
      assign keep[gi] = (start <= IDX) && (IDX < fill);
      assign pad[gi]  = (IDX == fill);
      assign tail[gi] = (IDX > fill);
    end
  endgenerate

endmodule

// File: rtl/sha256_block_padder.sv
// Packs message beats into 512-bit SHA-256 blocks and appends 0x80 padding plus the bit length.
// Optional SHA256_PADDER_LEN_OUT_EN adds msg_bits_o carrying the message bit length.
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int IF_DATA_W = 256,
  parameter int IF_BYTES  = IF_DATA_W / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [IF_DATA_W-1:0]          in_data_i,
  input  logic [$clog2(IF_BYTES+1)-1:0] in_bytes_i,
  input  logic                          in_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [SHA256_BLOCK_W-1:0]     out_block_o,
  output logic                          out_last_o
`ifdef SHA256_PADDER_LEN_OUT_EN
  ,
  output logic [SHA256_LEN_W-1:0]       msg_bits_o
`endif
);

  localparam int BYTES_W  = $clog2(IF_BYTES + 1);
  localparam int BEATS    = SHA256_BLOCK_BYTES / IF_BYTES;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IF_SHIFT = $clog2(IF_BYTES);

  pad_state_e                  state_reg;
  logic [CNT_W-1:0]            beat_cnt_reg;
  logic [SHA256_LEN_W-1:0]     bit_cnt_reg;
  logic [SHA256_BLOCK_W-1:0]   block_reg;
  logic                        out_valid_reg;
  logic                        out_last_reg;
  logic                        in_ready_reg;
  logic                        extra_pend_reg;
  logic                        extra_pad_reg;

  logic [SHA256_OFF_W-1:0]       offset;
  logic [SHA256_OFF_W-1:0]       fill;
  logic [SHA256_LEN_W-1:0]       bit_sum;
  logic [SHA256_BLOCK_BYTES-1:0] keep;
  logic [SHA256_BLOCK_BYTES-1:0] pad;
  logic [SHA256_BLOCK_BYTES-1:0] tail;
  logic [SHA256_BLOCK_W-1:0]     merged;
  logic [SHA256_BLOCK_W-1:0]     block_next;
  logic                          accept;
  logic                          len_fits;

  assign offset   = SHA256_OFF_W'({beat_cnt_reg, {IF_SHIFT{1'b0}}});
  assign fill     = offset + SHA256_OFF_W'(in_bytes_i);
  assign bit_sum  = bit_cnt_reg + (SHA256_LEN_W'(in_bytes_i) << 3);
  assign accept   = in_valid_i && in_ready_reg && (state_reg == ST_FILL);
  assign len_fits = fill < SHA256_OFF_W'(SHA256_LEN_OFFSET_BYTES);

  sha256_pad_mask #(
    .IF_BYTES (IF_BYTES),
    .BYTES_W  (BYTES_W)
  ) u_pad_mask (
    .offset (offset),
    .nbytes (in_bytes_i),
    .keep   (keep),
    .pad    (pad),
    .tail   (tail)
  );

  // Beat offsets are multiples of IF_BYTES, so block byte gi always maps to beat byte gi % IF_BYTES.
  generate
    for (genvar gi = 0; gi < SHA256_BLOCK_BYTES; gi++) begin : g_merge
      localparam int BI = gi % IF_BYTES;
      assign merged[SHA256_BLOCK_W-1-8*gi -: 8] =
        keep[gi]               ? in_data_i[IF_DATA_W-1-8*BI -: 8] :
        (in_last_i && pad[gi]) ? SHA256_PAD_BYTE :
        (in_last_i && tail[gi]) ? 8'h00 :
        block_reg[SHA256_BLOCK_W-1-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    block_next = merged;
    if (in_last_i && len_fits) begin
      block_next[SHA256_LEN_W-1:0] = bit_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_FILL;
      beat_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      in_ready_reg   <= 1'b0;
      extra_pend_reg <= 1'b0;
      extra_pad_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_FILL: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            block_reg   <= block_next;
            bit_cnt_reg <= bit_sum;
            if (in_last_i) begin
              beat_cnt_reg  <= '0;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              if (len_fits) begin
                state_reg    <= ST_EMIT_LAST;
                out_last_reg <= 1'b1;
              end else begin
                // Length no longer fits behind the data: it goes in a trailing block.
                state_reg      <= ST_EMIT;
                out_last_reg   <= 1'b0;
                extra_pend_reg <= 1'b1;
                extra_pad_reg  <= (fill == SHA256_OFF_W'(SHA256_BLOCK_BYTES));
              end
            end else if (beat_cnt_reg == CNT_W'(BEATS - 1)) begin
              beat_cnt_reg   <= '0;
              state_reg      <= ST_EMIT;
              in_ready_reg   <= 1'b0;
              out_valid_reg  <= 1'b1;
              out_last_reg   <= 1'b0;
              extra_pend_reg <= 1'b0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (out_ready_i) begin
            out_valid_reg <= 1'b0;
            if (extra_pend_reg) begin
              state_reg <= ST_EXTRA;
            end else begin
              state_reg    <= ST_FILL;
              in_ready_reg <= 1'b1;
            end
          end
        end
        ST_EXTRA: begin
          block_reg      <= sha256_len_block(extra_pad_reg, bit_cnt_reg);
          extra_pend_reg <= 1'b0;
          out_valid_reg  <= 1'b1;
          out_last_reg   <= 1'b1;
          state_reg      <= ST_EMIT_LAST;
        end
        ST_EMIT_LAST: begin
          if (out_ready_i) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            bit_cnt_reg   <= '0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_FILL;
          end
        end
        default: begin
          state_reg <= ST_FILL;
        end
      endcase
    end
  end

  // Short beats are only legal as the final beat of a message.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && accept) begin
      assert (in_last_i || (in_bytes_i == BYTES_W'(IF_BYTES)));
      assert (in_bytes_i <= BYTES_W'(IF_BYTES));
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign out_last_o  = out_last_reg;
  assign out_block_o = block_reg;

`ifdef SHA256_PADDER_LEN_OUT_EN
  assign msg_bits_o = bit_cnt_reg;
`endif

endmodule

// File: tb/tb_sha256_block_padder.sv
// Scoreboard bench for sha256_block_padder: 256-bit instance plus a 64-bit instance.
module tb_sha256_block_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         a_valid, a_ready, a_last, a_ovalid, a_oready, a_olast;
  logic [255:0] a_data;
  logic [5:0]   a_bytes;
  logic [511:0] a_block;

  logic         b_valid, b_ready, b_last, b_ovalid, b_oready, b_olast;
  logic [63:0]  b_data;
  logic [3:0]   b_bytes;
  logic [511:0] b_block;

`ifdef SHA256_PADDER_LEN_OUT_EN
  logic [63:0] a_bits, b_bits;
`endif

  sha256_block_padder #(.IF_DATA_W(256)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (a_valid),
    .in_ready_o  (a_ready),
    .in_data_i   (a_data),
    .in_bytes_i  (a_bytes),
    .in_last_i   (a_last),
    .out_valid_o (a_ovalid),
    .out_ready_i (a_oready),
    .out_block_o (a_block),
    .out_last_o  (a_olast)
`ifdef SHA256_PADDER_LEN_OUT_EN
    ,
    .msg_bits_o  (a_bits)
`endif
  );

  sha256_block_padder #(.IF_DATA_W(64)) dut64 (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_valid_i  (b_valid),
    .in_ready_o  (b_ready),
    .in_data_i   (b_data),
    .in_bytes_i  (b_bytes),
    .in_last_i   (b_last),
    .out_valid_o (b_ovalid),
    .out_ready_i (b_oready),
    .out_block_o (b_block),
    .out_last_o  (b_olast)
`ifdef SHA256_PADDER_LEN_OUT_EN
    ,
    .msg_bits_o  (b_bits)
`endif
  );

  typedef struct packed {
    logic [511:0] blk;
    logic         last;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] msg [0:511];

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic model_push(input int len);
    logic [7:0]  p [0:575];
    logic [63:0] bits;
    exp_t        e;
    int          nblk;
    nblk = (len + 72) / 64;
    for (int i = 0; i < nblk * 64; i++)
      p[i] = (i < len) ? msg[i] : ((i == len) ? 8'h80 : 8'h00);
    bits = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) p[nblk*64-8+k] = bits[63-8*k -: 8];
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[b*64+i];
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input int sel, input logic [255:0] data, input int nbytes, input bit last);
    int cyc;
    if (sel == 0) begin
      a_valid = 1'b1; a_data = data; a_bytes = 6'(nbytes); a_last = last;
    end else begin
      b_valid = 1'b1; b_data = data[255:192]; b_bytes = 4'(nbytes); b_last = last;
    end
    for (cyc = 0; cyc < 200; cyc++) begin
      if ((sel == 0) ? a_ready : b_ready) break;
      @(posedge clk); #1;
    end
    if (cyc == 200) begin
      checks++; errors++;
      $display("FAIL beat_accept sel=%0d: in_ready stayed 0, required 1 within 200 cycles", sel);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic send_msg(input int sel, input int len);
    int ifb, nbeats, nb;
    logic [255:0] data;
    ifb    = (sel == 0) ? 32 : 8;
    nbeats = (len == 0) ? 1 : (len + ifb - 1) / ifb;
    model_push(len);
    for (int k = 0; k < nbeats; k++) begin
      nb   = (k == nbeats - 1) ? (len - k * ifb) : ifb;
      data = '0;
      for (int j = 0; j < ifb; j++)
        data[255-8*j -: 8] = (j < nb) ? msg[k*ifb+j] : 8'($urandom);
      send_beat(sel, data, nb, k == nbeats - 1);
    end
  endtask

  task automatic wait_out(input int sel, output logic [511:0] blk, output logic last,
                          output logic rdy, output bit ok);
    ok = 1'b0; blk = '0; last = 1'b0; rdy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if ((sel == 0) ? (a_ovalid && a_oready) : (b_ovalid && b_oready)) begin
        blk  = (sel == 0) ? a_block : b_block;
        last = (sel == 0) ? a_olast : b_olast;
        rdy  = (sel == 0) ? a_ready : b_ready;
        ok   = 1'b1;
        $display("block sel=%0d last=%0d head=%h tail=%h", sel, last, blk[511:448], blk[63:0]);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
    a_data = '0; b_data = '0; a_bytes = '0; b_bytes = '0;
    a_oready = 1'b1; b_oready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", a_ready); end
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", a_ovalid); end
    checks++; if (a_olast !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", a_olast); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready64: got %b want 0", b_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready64: got %b want 1", b_ready); end
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL rel_out_valid: got %b want 0", a_ovalid); end
  endtask

  task automatic check_abc(input string tag);
    logic [511:0] blk; logic last, rdy; bit ok; exp_t e;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(0, 3);
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid %b want 1", tag, a_ovalid); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_low: in_ready %b want 0", tag, a_ready); end
`ifdef SHA256_PADDER_LEN_OUT_EN
    checks++; if (a_bits !== 64'd24) begin errors++; $display("FAIL %s_msg_bits: got %0d want 24", tag, a_bits); end
`endif
    wait_out(0, blk, last, rdy, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || blk !== e.blk) begin errors++; $display("FAIL %s_block: got %h want %h", tag, blk, e.blk); end
    checks++; if (blk[511:480] !== 32'h61626380 || blk[63:0] !== 64'h18 || blk[479:64] !== '0) begin
      errors++; $display("FAIL %s_words: got first %h last %h want 61626380 / 18", tag, blk[511:480], blk[63:0]);
    end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL %s_last: got %b want 1", tag, last); end
  endtask

  task automatic test_abc();
    check_abc("abc");
  endtask

  task automatic test_empty();
    logic [511:0] blk, want; logic last, rdy; bit ok; exp_t e;
    want = '0; want[511:504] = 8'h80;
    send_msg(0, 0);
    wait_out(0, blk, last, rdy, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || blk !== e.blk) begin errors++; $display("FAIL empty_block: got %h want %h", blk, e.blk); end
    checks++; if (blk !== want) begin errors++; $display("FAIL empty_const: got %h want %h", blk, want); end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL empty_last: got %b want 1", last); end
  endtask

  task automatic test_fill56();
    logic [511:0] blk; logic last, rdy; bit ok; exp_t e;
    for (int i = 0; i < 56; i++) msg[i] = 8'(i + 1);
    send_msg(0, 56);
    for (int b = 0; b < 2; b++) begin
      wait_out(0, blk, last, rdy, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || blk !== e.blk) begin errors++; $display("FAIL fill56_block%0d: got %h want %h", b, blk, e.blk); end
      checks++; if (last !== e.last) begin errors++; $display("FAIL fill56_last%0d: got %b want %b", b, last, e.last); end
    end
    checks++; if (blk[511:64] !== '0 || blk[63:0] !== 64'h1C0) begin
      errors++; $display("FAIL fill56_len: got %h want 1c0 with zero head", blk[63:0]);
    end
  endtask

  task automatic test_w64_full();
    logic [511:0] blk; logic last, rdy; bit ok; exp_t e;
    for (int i = 0; i < 64; i++) msg[i] = 8'hA0 ^ 8'(i);
    send_msg(1, 64);
    for (int b = 0; b < 2; b++) begin
      wait_out(1, blk, last, rdy, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || blk !== e.blk) begin errors++; $display("FAIL w64_block%0d: got %h want %h", b, blk, e.blk); end
      checks++; if (last !== e.last) begin errors++; $display("FAIL w64_last%0d: got %b want %b", b, last, e.last); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL w64_ready%0d: in_ready %b want 0", b, rdy); end
    end
    checks++; if (blk[511:504] !== 8'h80 || blk[503:64] !== '0 || blk[63:0] !== 64'h200) begin
      errors++; $display("FAIL w64_extra: got head %h len %h want 80 / 200", blk[511:504], blk[63:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] blk, held; logic last, rdy; bit ok; exp_t e;
    for (int i = 0; i < 5; i++) msg[i] = 8'h30 + 8'(i);
    a_oready = 1'b0;
    send_msg(0, 5);
    held = a_block;
    for (int c = 0; c < 5; c++) begin
      checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", c, a_ovalid); end
      checks++; if (a_block !== held) begin errors++; $display("FAIL bp_stable c%0d: got %h want %h", c, a_block, held); end
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0", c, a_ready); end
      @(posedge clk); #1;
    end
    a_oready = 1'b1;
    wait_out(0, blk, last, rdy, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || blk !== e.blk) begin errors++; $display("FAIL bp_block: got %h want %h", blk, e.blk); end
    checks++; if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after: out_valid %b in_ready %b want 0 1", a_ovalid, a_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] data;
    data = '0;
    for (int j = 0; j < 32; j++) data[255-8*j -: 8] = 8'hC0 + 8'(j);
    send_beat(0, data, 32, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL rstmid_valid c%0d: got %b want 0", c, a_ovalid); end
      @(posedge clk); #1;
    end
    check_abc("rstmid_abc");
  endtask

  task automatic test_back_to_back();
    int lens[9];
    int total;
    lens = '{55, 63, 64, 119, 120, 128, 0, 0, 0};
    for (int i = 6; i < 9; i++) lens[i] = $urandom_range(0, 150);
    total = 0;
    for (int i = 0; i < 9; i++) total += (lens[i] + 72) / 64;
    fork
      begin
        for (int m = 0; m < 9; m++) begin
          for (int i = 0; i < lens[m]; i++) msg[i] = 8'($urandom);
          send_msg(0, lens[m]);
        end
      end
      begin
        logic [511:0] blk; logic last, rdy; bit ok; exp_t e;
        for (int n = 0; n < total; n++) begin
          wait_out(0, blk, last, rdy, ok);
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_extra n%0d: unexpected block %h", n, blk);
          end else begin
            e = exp_q.pop_front();
            if (!ok || blk !== e.blk || last !== e.last) begin
              errors++; $display("FAIL b2b_block n%0d: got %h/%b want %h/%b", n, blk, last, e.blk, e.last);
            end
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_fill56();
    test_w64_full();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_block_padder.md
SHA256_BLOCK_PADDER -- requirements
Module: sha256_block_padder

Interface
REQ-001 SHALL have parameter IF_DATA_W, default 256, input beat width in bits; legal values 64, 128, 256, 512.
REQ-002 SHALL have parameter IF_BYTES, default IF_DATA_W/8, derived beat width in bytes; not overridden.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_n_i, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-006 SHALL have port in_ready_o, output, 1, input beat accepted when high with in_valid_i.
REQ-007 SHALL have port in_data_i, input, IF_DATA_W, message bytes, first byte in MSBs (big-endian).
REQ-008 SHALL have port in_bytes_i, input, clog2(IF_BYTES+1), valid byte count; 0..IF_BYTES on last beat, IF_BYTES otherwise.
REQ-009 SHALL have port in_last_i, input, 1, final beat of message.
REQ-010 SHALL have port out_valid_o, output, 1, padded 512-bit block valid.
REQ-011 SHALL have port out_ready_i, input, 1, consumer accepts block.
REQ-012 SHALL have port out_block_o, output, 512, SHA-256 message block, byte 0 in bits [511:504].
REQ-013 SHALL have port out_last_o, output, 1, block is final block of message.

Function
REQ-014 SHALL implement FSM states FILL, EMIT, EMIT_LAST, EXTRA.
REQ-015 FILL: SHALL hold in_ready_o=1 and write each accepted beat at byte offset beat_cnt*IF_BYTES, then advance beat_cnt.
REQ-016 A non-last beat completing 64 bytes SHALL go to EMIT with out_last_o=0.
REQ-017 A last beat SHALL place 0x80 directly after its valid bytes and zero all later bytes.
REQ-018 If the last beat's total block fill is <=55 bytes, SHALL write the 64-bit bit length into bytes 56..63 and go to EMIT_LAST.
REQ-019 If the fill is 56..63 bytes, SHALL go to EMIT, then EXTRA; the EXTRA block is zeros plus the length.
REQ-020 If the fill is exactly 64 bytes, SHALL go to EMIT, then EXTRA; the EXTRA block is 0x80, zeros, then the length.
REQ-021 EXTRA SHALL build the block in one cycle, then go to EMIT_LAST.
REQ-022 in_ready_o SHALL be 0 in EMIT, EMIT_LAST and EXTRA.
REQ-023 out_valid_o SHALL be 1 only in EMIT and EMIT_LAST; out_block_o and out_last_o SHALL stay stable until out_ready_i.
REQ-024 On handshake, EMIT SHALL return to FILL or go to EXTRA, and EMIT_LAST SHALL return to FILL with the bit count cleared.
REQ-025 The bit counter SHALL be 64 bits, add 8*in_bytes_i per accepted beat, and wrap modulo 2^64.
REQ-026 An empty message (in_last_i=1, in_bytes_i=0 at beat_cnt=0) SHALL produce one block: 0x80, zeros, length 0.
REQ-027 in_bytes_i<IF_BYTES without in_last_i is illegal; behaviour is undefined and flagged by an assertion.
REQ-028 Latency SHALL be: out_valid_o rises the cycle after the beat that completes a block.

Reset
REQ-029 While rst_n_i=0 at a clock edge: state=FILL, beat_cnt=0, bit count=0, out_valid_o=0, out_last_o=0, in_ready_o=0.
REQ-030 Reset mid-message SHALL discard the partial block and any pending output block.
REQ-031 in_ready_o SHALL go to 1 the first cycle after reset is released.

Configuration
REQ-032 With macro SHA256_PADDER_LEN_OUT_EN defined, SHALL add port msg_bits_o, output, 64, the message bit length, valid while out_valid_o && out_last_o.
REQ-033 Without SHA256_PADDER_LEN_OUT_EN, msg_bits_o SHALL be absent and function otherwise identical.

Structure
REQ-034 sha256_pkg SHALL gain SHA256_LEN_W=64, SHA256_PAD_BYTE=8'h80, SHA256_LEN_OFFSET_BYTES=56 and the FSM state enum typedef.
REQ-035 A single combinational sub-module sha256_pad_mask SHALL generate the byte keep mask and 0x80 position from in_bytes_i and the offset.

Verification
REQ-036 "abc" (0x616263, in_bytes_i=3, last, IF_DATA_W=256) -> one block 0x61626380, zeros, final word 0x18, out_last_o=1.
REQ-037 Empty message (in_bytes_i=0, last) -> one block 0x80 then zeros, length 0, out_last_o=1.
REQ-038 56-byte message -> block 1: data+0x80+zeros, out_last_o=0; block 2: zeros, length 0x1C0, out_last_o=1.
REQ-039 64-byte message with IF_DATA_W=64 -> data block, then 0x80, zeros, length 0x200; in_ready_o low during both emits.
REQ-040 out_ready_i held 0 for 5 cycles -> out_block_o stable and in_ready_o=0 throughout; block accepted on cycle 6.
REQ-041 rst_n_i=0 after 1 of 2 beats -> no output; next message "abc" matches REQ-036 exactly.
